perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CNT, default 4, number of counters; legal range 2..16.
REQ-002 SHALL have parameter WIDTH, default 32, bit width of every counter; legal range 8..64.
REQ-003 SHALL have parameter SATURATE, default 0, overflow mode; 0 = wrap, 1 = saturate at all-ones.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit, global count enable.
REQ-007 SHALL have port stall, input, 1 bit, pipeline stall; high means no instruction retires this cycle.
REQ-008 SHALL have port event_in, input, NUM_CNT-2 bits, one-cycle event pulses for counters 2..NUM_CNT-1.
REQ-009 SHALL have port clear, input, 1 bit, synchronous zeroing of all live counters and overflow flags.
REQ-010 SHALL have port snap, input, 1 bit, request to copy all live counters into shadow registers.
REQ-011 SHALL have port rd_idx, input, $clog2(NUM_CNT) bits, shadow counter select.
REQ-012 SHALL have port rd_data, output, WIDTH bits, shadow value of counter rd_idx.
REQ-013 SHALL have port ovf, output, NUM_CNT bits, sticky per-counter overflow flags.
REQ-014 SHALL have port snap_valid, output, 1 bit, indicating shadow registers hold a capture.

Function
REQ-015 Counter 0 (cycle counter) SHALL increment by 1 every cycle in which enable=1.
REQ-016 Counter 1 (instruction counter) SHALL increment by 1 in every cycle with enable=1 and stall=0.
REQ-017 Counter k≥2 SHALL increment by 1 in every cycle with enable=1 and event_in[k-2]=1.
REQ-018 With enable=0, no live counter SHALL change, but clear and snap SHALL still take effect.
REQ-019 With SATURATE=0, an increment at all-ones SHALL wrap to 0 and set ovf[k] on the same edge.
REQ-020 With SATURATE=1, an increment at all-ones SHALL hold all-ones and set ovf[k].
REQ-021 ovf[k] SHALL remain set until clear or reset.
REQ-022 clear SHALL override any same-cycle increment; the counter becomes 0, not 1.
REQ-023 On snap, shadow[k] SHALL capture each live counter's value as held before that edge's update; all counters capture on the same edge.
REQ-024 snap and clear in the same cycle: shadows SHALL capture the pre-clear values, and live counters SHALL clear.
REQ-025 snap_valid SHALL rise on the edge after the first snap and stay high until reset; clear SHALL NOT affect it.
REQ-026 rd_data SHALL be combinational from the shadow registers (zero latency); rd_idx ≥ NUM_CNT SHALL return 0.
REQ-027 Shadow registers SHALL change only on snap or reset.

Reset
REQ-028 On reset=1 at a clock edge, all live counters, all shadows, ovf and snap_valid SHALL become 0.
REQ-029 reset SHALL dominate clear, snap and every increment in the same cycle.
REQ-030 After reset, rd_data SHALL read 0 for every rd_idx.

Structure
REQ-031 Shared package perf_pkg SHALL hold:
- counter index constants CNT_CYCLE=0, CNT_INSTR=1, CNT_EV_BASE=2;
- the SATURATE mode encodings.
REQ-032 Sub-module perf_counter SHALL implement one counter: WIDTH-bit, with inc, clr, sat-mode and sticky ovf.
REQ-033 perf_counter SHALL be instantiated NUM_CNT times in a generate loop.
REQ-034 Shadow registers and the read mux SHALL live in perf_counter_bank.

Verification (NUM_CNT=4, WIDTH=8)
REQ-035 Reset, then enable=1 for 10 cycles with stall high on cycles 3-5, then snap -> rd_idx 0 reads 10, rd_idx 1 reads 7.
REQ-036 SATURATE=0, drive counter 0 to 255 then one more enabled cycle -> counter 0 = 0 and ovf[0]=1; ovf[0] stays 1 for 20 cycles.
REQ-037 SATURATE=1, same stimulus as REQ-036 -> counter 0 holds 255 and ovf[0]=1.
REQ-038 Counter 2 at 50, then event_in[0]=1 with clear=1 and snap=1 in the same cycle -> shadow[2]=50, live counter 2 = 0, ovf=0.
REQ-039 Counters non-zero with snap, then reset=1 in the same cycle -> all counters, shadows, ovf and snap_valid = 0.
REQ-040 rd_idx=3 after event_in[1] pulsed 5 times and snap -> rd_data=5; shadow value unchanged by 5 further events without snap.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared constants for the performance counter bank.
package perf_pkg;

  // Fixed counter slots; event counters start at CNT_EV_BASE.
  localparam int unsigned CNT_CYCLE   = 0;
  localparam int unsigned CNT_INSTR   = 1;
  localparam int unsigned CNT_EV_BASE = 2;

  // Overflow behaviour encodings for the SATURATE parameter.
  localparam int unsigned SAT_WRAP = 0;
  localparam int unsigned SAT_HOLD = 1;

endpackage : perf_pkg

// File: rtl/perf_counter.sv
// Single WIDTH-bit event counter with clear, wrap/saturate mode and sticky overflow.
module perf_counter
  import perf_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SATURATE = SAT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  // Count update; clear beats increment, reset beats everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (count == ALL_ONES) begin
        ovf <= 1'b1;
        if (SATURATE == SAT_HOLD) begin
          count <= ALL_ONES;
        end else begin
          count <= '0;
        end
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule : perf_counter

// File: rtl/perf_counter_bank.sv
// Bank of cycle/instruction/event counters with snapshot shadows and a read mux.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CNT  = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SATURATE = SAT_WRAP
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       stall,
  input  logic [NUM_CNT-3:0]         event_in,
  input  logic                       clear,
  input  logic                       snap,
  input  logic [$clog2(NUM_CNT)-1:0] rd_idx,
  output logic [WIDTH-1:0]           rd_data,
  output logic [NUM_CNT-1:0]         ovf,
  output logic                       snap_valid
);

  logic [NUM_CNT-1:0] inc;
  logic [WIDTH-1:0]   live   [NUM_CNT];
  logic [WIDTH-1:0]   shadow [NUM_CNT];

  // One counter per slot; the increment source depends on the slot role.
  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    if (k == CNT_CYCLE) begin : g_cycle
      assign inc[k] = enable;
    end else if (k == CNT_INSTR) begin : g_instr
      assign inc[k] = enable & ~stall;
    end else begin : g_event
      assign inc[k] = enable & event_in[k-CNT_EV_BASE];
    end

    perf_counter #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[k]),
      .clr   (clear),
      .count (live[k]),
      .ovf   (ovf[k])
    );
  end

  // Shadow capture samples pre-update live values; clear never touches shadows.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CNT); i++) begin
        shadow[i] <= '0;
      end
      snap_valid <= 1'b0;
    end else if (snap) begin
      for (int i = 0; i < int'(NUM_CNT); i++) begin
        shadow[i] <= live[i];
      end
      snap_valid <= 1'b1;
    end
  end

  // Zero-latency shadow read; unpopulated indices read as zero.
  always_comb begin
    rd_data = '0;
    if (32'(rd_idx) < NUM_CNT) begin
      rd_data = shadow[rd_idx];
    end
  end

endmodule : perf_counter_bank

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: wrap and saturate instances plus a 5-counter instance.
module tb_perf_counter_bank;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       stall;
  logic [1:0] event_in;
  logic       clear;
  logic       snap;
  logic [1:0] rd_idx;
  logic [2:0] rd_idx5;

  logic [7:0] rd_w, rd_s, rd_5;
  logic [3:0] ovf_w, ovf_s;
  logic [4:0] ovf_5;
  logic       sv_w, sv_s, sv_5;

  int checks = 0;
  int errors = 0;

  perf_counter_bank #(.NUM_CNT(4), .WIDTH(8), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall), .event_in(event_in),
    .clear(clear), .snap(snap), .rd_idx(rd_idx), .rd_data(rd_w), .ovf(ovf_w),
    .snap_valid(sv_w)
  );

  perf_counter_bank #(.NUM_CNT(4), .WIDTH(8), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall), .event_in(event_in),
    .clear(clear), .snap(snap), .rd_idx(rd_idx), .rd_data(rd_s), .ovf(ovf_s),
    .snap_valid(sv_s)
  );

  // Counter 4 of this instance mirrors event_in[0], like counter 2.
  perf_counter_bank #(.NUM_CNT(5), .WIDTH(8), .SATURATE(0)) u_five (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall),
    .event_in({event_in[0], event_in}), .clear(clear), .snap(snap),
    .rd_idx(rd_idx5), .rd_data(rd_5), .ovf(ovf_5), .snap_valid(sv_5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst, en, stl;
    logic [1:0] ev;
    logic       clr, snp;
    logic [1:0] idx;
    logic [7:0] exp_rd;
    logic [3:0] exp_ovf;
    logic       exp_sv;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string n, input bit rst, input bit en, input bit stl,
                     input bit [1:0] ev, input bit clr, input bit snp,
                     input bit [1:0] idx, input bit [7:0] rd, input bit [3:0] ov,
                     input bit sv);
    vec_t v;
    v.name = n; v.rst = rst; v.en = en; v.stl = stl; v.ev = ev;
    v.clr = clr; v.snp = snp; v.idx = idx;
    v.exp_rd = rd; v.exp_ovf = ov; v.exp_sv = sv;
    tbl.push_back(v);
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Apply inputs, let one rising edge pass, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable = 1'b0; stall = 1'b0; event_in = 2'b00;
    clear = 1'b0; snap = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd_idx = 2'd0; rd_idx5 = 3'd0;
    idle_inputs();

    // Table: cycle/instr counts, event counting, shadow hold, clear over increment.
    add("reset", 1, 0, 0, 2'b00, 0, 0, 2'd0, 8'd0, 4'h0, 0);
    for (int c = 1; c <= 10; c++)
      add("run", 0, 1, (c >= 3 && c <= 5), 2'b00, 0, 0, 2'd0, 8'd0, 4'h0, 0);
    add("snap_cyc",   0, 0, 0, 2'b00, 0, 1, 2'd0, 8'd10, 4'h0, 1);
    add("rd_instr",   0, 0, 0, 2'b00, 0, 0, 2'd1, 8'd7,  4'h0, 1);
    add("rd_ev0",     0, 0, 0, 2'b00, 0, 0, 2'd2, 8'd0,  4'h0, 1);
    for (int c = 0; c < 5; c++)
      add("ev1_pulse", 0, 1, 1, 2'b10, 0, 0, 2'd3, 8'd0, 4'h0, 1);
    add("snap_ev1",   0, 0, 0, 2'b00, 0, 1, 2'd3, 8'd5,  4'h0, 1);
    for (int c = 0; c < 5; c++)
      add("ev1_nosnap", 0, 1, 1, 2'b10, 0, 0, 2'd3, 8'd5, 4'h0, 1);
    add("snap_ev1b",  0, 0, 0, 2'b00, 0, 1, 2'd3, 8'd10, 4'h0, 1);
    add("rd_cyc20",   0, 0, 0, 2'b00, 0, 0, 2'd0, 8'd20, 4'h0, 1);
    add("rd_instr7",  0, 0, 0, 2'b00, 0, 0, 2'd1, 8'd7,  4'h0, 1);
    add("clr_inc",    0, 1, 0, 2'b11, 1, 0, 2'd3, 8'd10, 4'h0, 1);
    add("snap_clr",   0, 0, 0, 2'b00, 0, 1, 2'd0, 8'd0,  4'h0, 1);
    add("rd_ev1_clr", 0, 0, 0, 2'b00, 0, 0, 2'd3, 8'd0,  4'h0, 1);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; enable = tbl[i].en; stall = tbl[i].stl;
      event_in = tbl[i].ev; clear = tbl[i].clr; snap = tbl[i].snp;
      rd_idx = tbl[i].idx;
      tick();
      chk({tbl[i].name, "_rd_w"},  64'(rd_w),  64'(tbl[i].exp_rd));
      chk({tbl[i].name, "_rd_s"},  64'(rd_s),  64'(tbl[i].exp_rd));
      chk({tbl[i].name, "_ovf_w"}, 64'(ovf_w), 64'(tbl[i].exp_ovf));
      chk({tbl[i].name, "_sv_w"},  64'(sv_w),  64'(tbl[i].exp_sv));
    end
    reset = 1'b0;

    // Overflow: wrap vs saturate on the cycle counter, sticky flag, clear.
    do_reset();
    enable = 1'b1; stall = 1'b1;
    repeat (255) tick();
    enable = 1'b0; snap = 1'b1; rd_idx = 2'd0;
    tick();
    chk("pre_ovf_rd_w", 64'(rd_w), 64'd255);
    chk("pre_ovf_rd_s", 64'(rd_s), 64'd255);
    chk("pre_ovf_ovf_w", 64'(ovf_w), 64'h0);
    snap = 1'b0; enable = 1'b1;
    tick();
    chk("ovf_same_edge_w", 64'(ovf_w), 64'h1);
    chk("ovf_same_edge_s", 64'(ovf_s), 64'h1);
    enable = 1'b0; snap = 1'b1;
    tick();
    chk("wrap_rd", 64'(rd_w), 64'd0);
    chk("sat_rd",  64'(rd_s), 64'd255);
    snap = 1'b0; enable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("ovf_sticky_w", 64'(ovf_w[0]), 64'd1);
      chk("ovf_sticky_s", 64'(ovf_s[0]), 64'd1);
    end
    enable = 1'b0; snap = 1'b1;
    tick();
    chk("wrap_after20", 64'(rd_w), 64'd20);
    chk("sat_after20",  64'(rd_s), 64'd255);
    snap = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ovf_w", 64'(ovf_w), 64'h0);
    chk("clr_ovf_s", 64'(ovf_s), 64'h0);
    chk("clr_keeps_sv", 64'(sv_w), 64'd1);
    stall = 1'b0;

    // Event + clear + snap on the same edge: shadow gets pre-clear value.
    do_reset();
    enable = 1'b1; stall = 1'b1; event_in = 2'b01;
    repeat (50) tick();
    clear = 1'b1; snap = 1'b1; rd_idx = 2'd2;
    tick();
    chk("clrsnap_shadow2", 64'(rd_w), 64'd50);
    chk("clrsnap_ovf", 64'(ovf_w), 64'h0);
    idle_inputs(); snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("clrsnap_live2", 64'(rd_w), 64'd0);
    rd_idx = 2'd0; #1;
    chk("clrsnap_live0", 64'(rd_w), 64'd0);

    // Reset dominates a same-cycle snap and increments.
    do_reset();
    enable = 1'b1; event_in = 2'b11;
    repeat (3) tick();
    snap = 1'b1;
    tick();
    rd_idx = 2'd0; #1;
    chk("pre_rst_rd", 64'(rd_w), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0; idle_inputs();
    chk("rst_sv", 64'(sv_w), 64'd0);
    chk("rst_ovf", 64'(ovf_w), 64'h0);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i); #1;
      chk("rst_rd", 64'(rd_w), 64'd0);
    end
    snap = 1'b1;
    tick();
    snap = 1'b0;
    rd_idx = 2'd0; #1;
    chk("rst_live0", 64'(rd_w), 64'd0);

    // Read mux with indices beyond the populated counters.
    do_reset();
    enable = 1'b1; event_in = 2'b01;
    repeat (3) tick();
    idle_inputs(); snap = 1'b1;
    tick();
    snap = 1'b0;
    rd_idx5 = 3'd0; #1;
    chk("five_rd0", 64'(rd_5), 64'd3);
    rd_idx5 = 3'd4; #1;
    chk("five_rd4", 64'(rd_5), 64'd3);
    for (int i = 5; i < 8; i++) begin
      rd_idx5 = 3'(i); #1;
      chk("five_rd_oob", 64'(rd_5), 64'd0);
    end
    chk("five_sv", 64'(sv_5), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_perf_counter_bank
